// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared definitions for the RTC bus arbiter: FSM state encoding, default
// phase timing and the inactive level of the active-low bus strobes.
package rtc_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_ACT = 3'd1,
        A_REC = 3'd2,
        D_ACT = 3'd3,
        D_REC = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int T_PH_DEF  = 10;
    localparam int T_GAP_DEF = 5;

    localparam logic STROBE_OFF = 1'b1;

    // Index width for a requester count; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Requester handshake plus RTC multiplexed bus signals. The arbiter sits on
// the slave modport; requesters and the RTC pad model sit on the master side.
interface rtc_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   we;
    logic [8*N_REQ-1:0] addr;
    logic [8*N_REQ-1:0] wdata;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [7:0]         rdata;
    logic [7:0]         ADin;
    logic [7:0]         ADout;
    logic               oe;
    logic               ad;
    logic               cs;
    logic               rd;
    logic               wr;
    logic               busy;

    modport slave (
        input  req, we, addr, wdata, ADin,
        output gnt, done, rdata, ADout, oe, ad, cs, rd, wr, busy
    );

    modport master (
        output req, we, addr, wdata, ADin,
        input  gnt, done, rdata, ADout, oe, ad, cs, rd, wr, busy
    );
endinterface

// File: rtl/rtc_bus_arbiter_rr_arbiter.sv
// Round-robin requester selection. The winner is the first set request
// found searching upward from the priority pointer with wrap-around; the
// pointer moves just past the winner whenever a grant is taken.
module rr_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;

    // Scan from ptr upward, keeping only the first requester found.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid            = 1'b1;
                winner_idx       = cand;
                winner_oh[cand]  = 1'b1;
            end
        end
    end

    // Priority pointer: cleared by reset, moved past the winner on a grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (winner_idx == IDX_W'(N_REQ - 1)) ? '0 : winner_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Shares the RTC multiplexed address/data bus between N_REQ requesters.
// One granted request becomes one complete bus transaction: address strobe
// phase, recovery, data write/read strobe phase, recovery, completion pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus released, arbitrating among pending requests
// A_ACT | address phase, ad/cs/wr low, latched address driven
// A_REC | recovery after the address phase, all strobes released
// D_ACT | data phase, wr low with wdata driven, or rd low with bus released
// D_REC | recovery after the data phase
// DONE  | done pulse to the granted requester, then back to IDLE
//
// Every output is a register. Strobe/bus outputs are registered from the
// current state, so bus activity appears one cycle after the state (and gnt)
// and each phase shows for exactly its programmed length. gnt and done are
// registered from the state transitions so done lands 2*T_PH + 2*T_GAP
// cycles after gnt.
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int T_PH  = T_PH_DEF,
    parameter int T_GAP = T_GAP_DEF,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    rtc_bus_arbiter_if.slave    bus
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam logic [CNT_W-1:0] PH_LOAD  = CNT_W'(T_PH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(T_GAP - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    logic [IDX_W-1:0] l_idx;
    logic             l_we;
    logic [7:0]       l_addr;
    logic [7:0]       l_wdata;
    logic             latch;

    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;

    logic [N_REQ-1:0] gnt_n;
    logic [N_REQ-1:0] done_n;
    logic             ad_n;
    logic             cs_n;
    logic             rd_n;
    logic             wr_n;
    logic             oe_n;
    logic [7:0]       adout_n;

    // High during the cycle in which rd shows its last low cycle; rdata
    // samples ADin at the end of that cycle.
    logic             last_rd;
    logic             last_rd_n;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.req),
        .advance    (latch),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .valid      (win_valid)
    );

    // Next state, phase timer reload and next values of all registered outputs.
    always_comb begin
        state_n   = state;
        cnt_n     = (state == IDLE) ? cnt : cnt - 1'b1;
        latch     = 1'b0;
        gnt_n     = '0;
        done_n    = '0;
        ad_n      = STROBE_OFF;
        cs_n      = STROBE_OFF;
        rd_n      = STROBE_OFF;
        wr_n      = STROBE_OFF;
        oe_n      = 1'b0;
        adout_n   = bus.ADout;
        last_rd_n = 1'b0;

        case (state)
            IDLE: begin
                if (win_valid) begin
                    latch   = 1'b1;
                    gnt_n   = win_oh;
                    cnt_n   = PH_LOAD;
                    state_n = A_ACT;
                end
            end
            A_ACT: begin
                ad_n    = 1'b0;
                cs_n    = 1'b0;
                wr_n    = 1'b0;
                oe_n    = 1'b1;
                adout_n = l_addr;
                if (cnt == '0) begin
                    cnt_n   = GAP_LOAD;
                    state_n = A_REC;
                end
            end
            A_REC: begin
                if (cnt == '0) begin
                    cnt_n   = PH_LOAD;
                    state_n = D_ACT;
                end
            end
            D_ACT: begin
                cs_n = 1'b0;
                if (l_we) begin
                    wr_n    = 1'b0;
                    oe_n    = 1'b1;
                    adout_n = l_wdata;
                end else begin
                    rd_n      = 1'b0;
                    last_rd_n = (cnt == '0);
                end
                if (cnt == '0) begin
                    cnt_n   = GAP_LOAD;
                    state_n = D_REC;
                end
            end
            D_REC: begin
                if (cnt == '0) begin
                    cnt_n         = '0;
                    done_n[l_idx] = 1'b1;
                    state_n       = DONE;
                end
            end
            DONE: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State, timer, latched request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            l_idx     <= '0;
            l_we      <= 1'b0;
            l_addr    <= '0;
            l_wdata   <= '0;
            last_rd   <= 1'b0;
            bus.gnt   <= '0;
            bus.done  <= '0;
            bus.rdata <= '0;
            bus.ADout <= '0;
            bus.oe    <= 1'b0;
            bus.ad    <= STROBE_OFF;
            bus.cs    <= STROBE_OFF;
            bus.rd    <= STROBE_OFF;
            bus.wr    <= STROBE_OFF;
            bus.busy  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            last_rd <= last_rd_n;
            if (latch) begin
                l_idx   <= win_idx;
                l_we    <= bus.we[win_idx];
                l_addr  <= bus.addr[{win_idx, 3'b000} +: 8];
                l_wdata <= bus.wdata[{win_idx, 3'b000} +: 8];
            end
            if (last_rd) begin
                bus.rdata <= bus.ADin;
            end
            bus.gnt   <= gnt_n;
            bus.done  <= done_n;
            bus.ADout <= adout_n;
            bus.oe    <= oe_n;
            bus.ad    <= ad_n;
            bus.cs    <= cs_n;
            bus.rd    <= rd_n;
            bus.wr    <= wr_n;
            bus.busy  <= (state_n != IDLE);
        end
    end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Shares the RTC chip's multiplexed address/data bus between N_REQ requesters, e.g. the init, read-out, time-write, date-write and stopwatch-write sequencers.
- Each requester asks for one complete bus transaction: an address phase followed by a data write or data read.
- The block generates all bus strobes with programmable phase timing and returns read data to the winning requester.
- It replaces static mux selection of requester control words with a request/grant handshake plus round-robin arbitration.

Parameters:
- N_REQ, 4, number of requesters.
- T_PH, 10, clk cycles per active phase (address or data strobe low); legal range 1..2^CNT_W-1.
- T_GAP, 5, clk cycles of recovery after each active phase; legal range 1..2^CNT_W-1.
- CNT_W, 8, phase counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-low.
- req  in  N_REQ  per-requester transaction request, level; held until gnt.
- we  in  N_REQ  per-requester direction, 1 = write, 0 = read.
- addr  in  8*N_REQ  RTC register address, requester i on bits [8i+7:8i].
- wdata  in  8*N_REQ  write data, same packing as addr.
- gnt  out  N_REQ  one-hot, one-cycle pulse when the request is accepted.
- done  out  N_REQ  one-hot, one-cycle pulse when the transaction has completed.
- rdata  out  8  read data; valid while done is high, then held.
- ADin  in  8  RTC bus input.
- ADout  out  8  RTC bus output value.
- oe  out  1  bus drive enable; the top level tri-states AD when oe is 0.
- ad  out  1  address strobe, active-low.
- cs  out  1  chip select, active-low.
- rd  out  1  read strobe, active-low.
- wr  out  1  write strobe, active-low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst = 0 at the clock edge): state IDLE; ad, cs, rd and wr = 1; oe = 0; ADout = 0; gnt = 0; done = 0; rdata = 0; priority pointer = 0; counter = 0.
- Reset has priority over everything. A reset mid-transaction releases all strobes at that edge; no done pulse is issued.
- All outputs are registered.
- States: IDLE, A_ACT, A_REC, D_ACT, D_REC, DONE.
- IDLE:
  - If any req bit is 1, pick the winner: the first set bit searching from ptr upward, wrapping modulo N_REQ.
  - Latch the winner's index, we, addr and wdata.
  - Pulse gnt[winner] and set ptr = winner+1 mod N_REQ.
  - Load counter with T_PH-1 and go to A_ACT.
  - If no req bit is set, stay in IDLE.
- A_ACT: ad = 0, cs = 0, wr = 0, rd = 1, oe = 1, ADout = latched addr. When the counter reaches 0, load T_GAP-1 and go to A_REC.
- A_REC: all strobes = 1, oe = 0. When the counter reaches 0, load T_PH-1 and go to D_ACT.
- D_ACT, write: ad = 1, cs = 0, wr = 0, oe = 1, ADout = latched wdata.
- D_ACT, read: ad = 1, cs = 0, rd = 0, oe = 0. rdata captures ADin on the cycle where the counter is 0 (the last strobe-low cycle).
- D_ACT exit: when the counter reaches 0, load T_GAP-1 and go to D_REC.
- D_REC: all strobes = 1, oe = 0. When the counter reaches 0, go to DONE.
- DONE: pulse done[latched index] for 1 cycle, then go to IDLE.
- Latency: strobe activity starts on the cycle after gnt. From gnt to done is 2*T_PH + 2*T_GAP cycles.
- Back-to-back transactions: the earliest next gnt is 2 cycles after done (DONE, then IDLE re-arbitration).
- A requester that still holds req after its own done is arbitrated again, normally with lowest priority.
- req, we, addr and wdata are ignored outside IDLE. A requester may drop req any time after gnt.
- If req drops before gnt, the request is withdrawn and nothing is issued.
- Simultaneous requests: exactly one gnt bit is set, chosen round-robin, so no requester waits more than N_REQ-1 transactions.
- The counter decrements each cycle in non-IDLE states. It never wraps, because it is reloaded at every transition.
- cs stays low only in active phases; the bus is never driven (oe = 1) while rd = 0.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE = 0, A_ACT = 1, A_REC = 2, D_ACT = 3, D_REC = 4, DONE = 5;
  - default timing constants T_PH_DEF and T_GAP_DEF;
  - the strobe-inactive constant 1'b1.
- One natural sub-module: rr_arbiter. It is purely combinational plus ptr update: inputs req and ptr, outputs a one-hot winner and a valid flag.
- The FSM and phase timer stay in the top module.

Test Plan:
- Reset with req = 4'b1111 held for 3 cycles, then rst = 1 → during reset all strobes 1, oe = 0, gnt = 0; the first gnt after release is gnt = 4'b0001.
- Single write, req[2] = 1, we[2] = 1, addr = 8'h21, wdata = 8'h45, T_PH = 10, T_GAP = 5:
  - ad low for 10 cycles with ADout = 21;
  - 5 idle cycles;
  - wr low for 10 cycles with ADout = 45 and oe = 1;
  - 5 idle cycles;
  - done = 4'b0100 exactly 30 cycles after gnt.
- Single read, req[0] = 1, we[0] = 0, addr = 8'h22; bench drives ADin = 8'h37 only on the last rd-low cycle → rdata = 37 while done[0] is high; oe = 0 throughout D_ACT.
- Contention, req = 4'b1011 held continuously → grant order 0, 1, 3, 0, 1, 3; each next gnt 2 cycles after the previous done.
- Reset mid-operation: assert rst = 0 during D_ACT of a write → strobes 1 and oe 0 on the following edge; no done pulse; after release, arbitration restarts from ptr = 0.
- Boundary timing, T_PH = 1, T_GAP = 1 → each strobe is low for exactly 1 cycle; gnt-to-done = 4 cycles.
